// File: rtl/msrv_32_pkg.sv
// Shared MSRV32 pipeline definitions: control-word field layout, default widths
// and the legal range for elastic stage depth.
package msrv_32_pkg;

    localparam int MSRV32_DATA_W = 32;

    localparam int CTRL_RF_WR_EN_O     = 0;
    localparam int CTRL_RF_WR_EN_W     = 1;
    localparam int CTRL_CSR_WR_EN_O    = CTRL_RF_WR_EN_O + CTRL_RF_WR_EN_W;
    localparam int CTRL_CSR_WR_EN_W    = 1;
    localparam int CTRL_ALU_SRC_O      = CTRL_CSR_WR_EN_O + CTRL_CSR_WR_EN_W;
    localparam int CTRL_ALU_SRC_W      = 1;
    localparam int CTRL_LOAD_UNSIGNED_O = CTRL_ALU_SRC_O + CTRL_ALU_SRC_W;
    localparam int CTRL_LOAD_UNSIGNED_W = 1;
    localparam int CTRL_LOAD_SIZE_O    = CTRL_LOAD_UNSIGNED_O + CTRL_LOAD_UNSIGNED_W;
    localparam int CTRL_LOAD_SIZE_W    = 2;
    localparam int CTRL_ALU_OPCODE_O   = CTRL_LOAD_SIZE_O + CTRL_LOAD_SIZE_W;
    localparam int CTRL_ALU_OPCODE_W   = 4;
    localparam int CTRL_WB_MUX_SEL_O   = CTRL_ALU_OPCODE_O + CTRL_ALU_OPCODE_W;
    localparam int CTRL_WB_MUX_SEL_W   = 3;
    localparam int CTRL_CSR_OP_O       = CTRL_WB_MUX_SEL_O + CTRL_WB_MUX_SEL_W;
    localparam int CTRL_CSR_OP_W       = 3;

    localparam int MSRV32_CTRL_W = CTRL_CSR_OP_O + CTRL_CSR_OP_W;

    // Field order matches the offsets above, LSB first (rf_wr_en at bit 0).
    typedef struct packed {
        logic [CTRL_CSR_OP_W-1:0]     csr_op;
        logic [CTRL_WB_MUX_SEL_W-1:0] wb_mux_sel;
        logic [CTRL_ALU_OPCODE_W-1:0] alu_opcode;
        logic [CTRL_LOAD_SIZE_W-1:0]  load_size;
        logic                         load_unsigned;
        logic                         alu_src;
        logic                         csr_wr_en;
        logic                         rf_wr_en;
    } msrv32_ctrl_t;

    localparam int PIPE_DEPTH_MIN = 1;
    localparam int PIPE_DEPTH_MAX = 4;

    function automatic bit depth_ok(input int depth);
        return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/msrv_32_ptr_ctr.sv
// Wrap-around read/write pointer pair plus occupancy counter for a circular
// buffer of DEPTH entries; clear returns everything to zero.
module msrv_32_ptr_ctr
    import msrv_32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1,
    parameter int OCC_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic [OCC_W-1:0] o_count
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    // With DEPTH=1 the last slot is 0, so pointers never leave 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_inc) r_wr_ptr <= wrap_inc(r_wr_ptr);
            if (i_dec) r_rd_ptr <= wrap_inc(r_rd_ptr);
            if (i_inc && !i_dec)      r_count <= r_count + OCC_W'(1);
            else if (i_dec && !i_inc) r_count <= r_count - OCC_W'(1);
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;

endmodule

// File: rtl/msrv_32_pipe_reg_elastic.sv
// Elastic valid/ready pipeline stage holding DEPTH payload+control entries,
// with synchronous flush and a saturating count of entries dropped by flush.
module msrv_32_pipe_reg_elastic
    import msrv_32_pkg::*;
#(
    parameter int DATA_W = MSRV32_DATA_W,
    parameter int CTRL_W = MSRV32_CTRL_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                         ms_risc32_mp_clk_in,
    input  logic                         ms_risc32_mp_rst_n_in,
    input  logic                         in_valid_in,
    output logic                         in_ready_out,
    input  logic [DATA_W-1:0]            in_data_in,
    input  logic [CTRL_W-1:0]            in_ctrl_in,
    input  logic                         flush_in,
    output logic                         out_valid_out,
    input  logic                         out_ready_in,
    output logic [DATA_W-1:0]            out_data_out,
    output logic [CTRL_W-1:0]            out_ctrl_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out,
    output logic [CNT_W-1:0]             drop_cnt_out
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
    localparam logic [CNT_W-1:0] DROP_MAX = '1;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("msrv_32_pipe_reg_elastic: DEPTH must be in 1..4");
    end

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [CTRL_W-1:0] r_mem_ctrl [DEPTH];
    logic [DATA_W-1:0] r_last_data;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [OCC_W-1:0]  w_count;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic [SUM_W-1:0]  w_drop_sum;

    // Ready passes out_ready_in through so a full stage sustains one-per-cycle.
    assign w_out_valid = (w_count != '0);
    assign w_in_ready  = (w_count < OCC_W'(DEPTH)) | out_ready_in;
    assign w_push      = in_valid_in & w_in_ready;
    assign w_pop       = w_out_valid & out_ready_in;
    assign w_drop_sum  = SUM_W'(r_drop_cnt) + SUM_W'(w_count);

    msrv_32_ptr_ctr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .OCC_W (OCC_W)
    ) u_ptr_ctr (
        .i_clk    (ms_risc32_mp_clk_in),
        .i_rst_n  (ms_risc32_mp_rst_n_in),
        .i_inc    (w_push),
        .i_dec    (w_pop),
        .i_clr    (flush_in),
        .o_wr_ptr (w_wr_ptr),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count)
    );

    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_n_in) begin
        if (!ms_risc32_mp_rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_ctrl[i] <= '0;
            end
        end else if (w_push && !flush_in) begin
            r_mem_data[w_wr_ptr] <= in_data_in;
            r_mem_ctrl[w_wr_ptr] <= in_ctrl_in;
        end
    end

    // Last popped payload is kept so out_data_out stays put once the stage drains.
    always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_n_in) begin
        if (!ms_risc32_mp_rst_n_in) begin
            r_last_data <= '0;
            r_drop_cnt  <= '0;
        end else if (flush_in) begin
            r_drop_cnt <= (w_drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : w_drop_sum[CNT_W-1:0];
        end else if (w_pop) begin
            r_last_data <= r_mem_data[w_rd_ptr];
        end
    end

    assign in_ready_out  = w_in_ready;
    assign out_valid_out = w_out_valid;
    assign out_data_out  = w_out_valid ? r_mem_data[w_rd_ptr] : r_last_data;
    assign out_ctrl_out  = w_out_valid ? r_mem_ctrl[w_rd_ptr] : '0;
    assign count_out     = w_count;
    assign drop_cnt_out  = r_drop_cnt;

endmodule

// File: doc/msrv_32_pipe_reg_elastic.md
Name: msrv_32_pipe_reg_elastic

Overview:
Parametrised, elastic pipeline register for inter-stage boundaries of the MSRV32 core. It buffers DEPTH entries of a generic payload plus a control word, using valid/ready flow control. A synchronous flush squashes all held entries and zeroes the control fields. It replaces fixed per-stage register blocks with one reusable stage (decode->execute, execute->writeback).

Parameters:
DATA_W, 32, payload width (operands, pc, imm, rd/csr addresses packed by caller)
CTRL_W, 16, control-word width (wr enables, alu opcode, wb/csr selects); forced to 0 when squashed or invalid
DEPTH, 2, entries held, legal 1..4
CNT_W, 16, width of saturating flush-drop counter

Ports:
ms_risc32_mp_clk_in  input  1  core clock, rising edge
ms_risc32_mp_rst_n_in  input  1  asynchronous reset, active-low
in_valid_in  input  1  upstream entry valid
in_ready_out  output  1  stage can accept this cycle
in_data_in  input  DATA_W  upstream payload
in_ctrl_in  input  CTRL_W  upstream control word
flush_in  input  1  squash all entries (branch taken / trap)
out_valid_out  output  1  head entry valid
out_ready_in  input  1  downstream accepts head
out_data_out  output  DATA_W  head payload
out_ctrl_out  output  CTRL_W  head control, 0 when !out_valid_out
count_out  output  $clog2(DEPTH+1)  occupancy
drop_cnt_out  output  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Reset (asynchronous, ms_risc32_mp_rst_n_in=0): count=0, read/write pointers=0, all storage=0, drop_cnt=0. Outputs: out_valid_out=0, out_data_out=0, out_ctrl_out=0, count_out=0, drop_cnt_out=0, in_ready_out=1. Reset mid-transfer discards everything. No partial state survives.
- push = in_valid_in & in_ready_out; pop = out_valid_out & out_ready_in.
- in_ready_out = (count<DEPTH) | out_ready_in. This is a combinational pass-through, so a full buffer still accepts when the head pops the same cycle.
- out_valid_out = (count!=0). Data and ctrl come from the registered head entry. Latency in->out is 1 cycle; an empty stage never bypasses combinationally.
- Storage is a circular buffer. Pointers wrap from DEPTH-1 to 0; with DEPTH=1 the pointers are constant 0.
- Count update: push&!pop -> +1; pop&!push -> -1; both or neither -> unchanged. Both push and pop when full is legal.
- Payload hold: when !pop, out_data_out and out_ctrl_out are stable. When count returns to 0, out_data_out holds the last popped value. out_ctrl_out is forced to 0.
- Flush (flush_in=1 at clock edge): count<=0 and pointers<=0. A simultaneous push is dropped and a simultaneous pop is not counted. Storage contents are not cleared. From the next cycle out_valid_out=0 and out_ctrl_out=0.
- drop_cnt update on flush: drop_cnt<=min(drop_cnt+count, 2^CNT_W-1). Count is the occupancy before the edge, excluding any dropped incoming entry.
- in_ready_out is not gated by flush_in. Upstream is expected to squash its own valid.
- If in_valid_in drops without a handshake, no entry is written.

Decomposition:
- Shared package msrv_32_pkg holds:
  - control field offsets/widths (rf_wr_en, csr_wr_en, alu_src, load_unsigned, load_size[1:0], alu_opcode[3:0], wb_mux_sel[2:0], csr_op[2:0]) and the derived MSRV32_CTRL_W=16;
  - MSRV32_DATA_W=32 defaults;
  - a legal-DEPTH range check.
- One sub-module, msrv_32_ptr_ctr: a wrap-around pointer/occupancy counter with inc/dec/clear inputs, instantiated once. Storage stays inline.

Test Plan (DEPTH=2, DATA_W=32, CTRL_W=16 unless noted):
- Reset: hold rst_n=0 with in_valid_in=1 and data 0xDEADBEEF -> all outputs 0, in_ready_out=1. Release rst_n; push 0x11 ctrl 0x0003 -> next cycle out_valid_out=1, out_data_out=0x11, out_ctrl_out=0x0003, count_out=1.
- Fill and backpressure: out_ready_in=0, push 0xA1,0xA2 -> count_out=2, in_ready_out=0. A third push of 0xA3 with out_ready_in=0 is not accepted. Set out_ready_in=1 -> drains in order 0xA1,0xA2,0xA3.
- Full-throughput with pass-through: full and out_ready_in=1 with continuous pushes 0xB0.. -> one entry popped and one accepted per cycle, count_out stays 2, order preserved.
- Flush with 2 held plus simultaneous push: flush_in=1 -> next cycle out_valid_out=0, out_ctrl_out=0, count_out=0, drop_cnt_out=2. The pushed entry never appears.
- Drop-counter saturation (CNT_W=2): three flushes each with 2 held entries -> drop_cnt_out goes 2, 3, 3.
- Wrap-around (DEPTH=3): interleave pushes and pops for 10 entries with random out_ready_in -> output sequence equals input sequence and count_out never exceeds 3. Repeat with DEPTH=1 -> 1-cycle latency, full throughput with out_ready_in=1.
